// File: rtl/apu_fpu_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// | Module   : apu_fpu_share_arbiter_if                                      |
// | Brief    : core-side and FPU-side bundle of the shared APU/FPU arbiter   |
// | Revision : 1.0                                                           |
// ----------------------------------------------------------------------------
`default_nettype none

interface apu_fpu_share_arbiter_if #(
  parameter int NB_CORES = 4,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
);
  localparam int ID_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

  logic [NB_CORES-1:0]          core_req_i;
  logic [NB_CORES-1:0]          core_gnt_o;
  logic [NB_CORES*NARGS*32-1:0] core_operands_i;
  logic [NB_CORES*WOP-1:0]      core_op_i;
  logic [NB_CORES*NDSFLAGS-1:0] core_flags_i;
  logic [NB_CORES-1:0]          core_rvalid_o;
  logic [31:0]                  core_rdata_o;
  logic [NUSFLAGS-1:0]          core_rflags_o;

  logic                         fpu_req_o;
  logic                         fpu_gnt_i;
  logic [NARGS*32-1:0]          fpu_operands_o;
  logic [WOP-1:0]               fpu_op_o;
  logic [NDSFLAGS-1:0]          fpu_flags_o;
  logic [ID_W-1:0]              fpu_tag_o;
  logic                         fpu_rvalid_i;
  logic [31:0]                  fpu_rdata_i;
  logic [NUSFLAGS-1:0]          fpu_rflags_i;
  logic [ID_W-1:0]              fpu_rtag_i;

  logic                         busy_o;

  // Arbiter side
  modport slave (
    input  core_req_i, core_operands_i, core_op_i, core_flags_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
    output fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o, fpu_tag_o,
    input  fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rtag_i,
    output busy_o
  );

  // Environment side (cores plus FPU)
  modport master (
    output core_req_i, core_operands_i, core_op_i, core_flags_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
    input  fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o, fpu_tag_o,
    output fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rtag_i,
    input  busy_o
  );
endinterface

`default_nettype wire

// File: rtl/apu_fpu_share_arbiter.sv
// ----------------------------------------------------------------------------
// | Module   : apu_fpu_share_arbiter                                         |
// | Brief    : round-robin sharing of one FPU among NB_CORES APU masters,    |
// |            tag-based response demux, outstanding-op throttling.          |
// |            APU_ARB_PERF_EN adds per-core grant/stall counters.           |
// | Revision : 1.0                                                           |
// ----------------------------------------------------------------------------
`default_nettype none

module apu_fpu_share_arbiter #(
  parameter int  NB_CORES  = 4,
  parameter int  MAX_OUTST = 4,
  parameter int  NARGS     = 3,
  parameter int  WOP       = 6,
  parameter int  NDSFLAGS  = 15,
  parameter int  NUSFLAGS  = 5,
  localparam int ID_W      = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  apu_fpu_share_arbiter_if.slave bus
`ifdef APU_ARB_PERF_EN
  ,
  input  wire logic              perf_clr_i,
  input  wire logic [ID_W-1:0]   perf_sel_i,
  output logic      [63:0]       perf_cnt_o
`endif
);

  localparam int c_cnt_w = 4;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [c_cnt_w-1:0] r_outst_cnt;

  logic               w_any;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_rr_next;
  logic               w_can_issue;
  logic               w_fpu_req;
  logic               w_accept;
  logic               w_dec;
  logic               w_tag_legal;
  logic [NB_CORES-1:0] w_gnt;
  logic [NB_CORES-1:0] w_rvalid;

  // First requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    logic [ID_W:0] sum;
    w_any = 1'b0;
    w_win = '0;
    sum   = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NB_CORES)) begin
        sum = sum - (ID_W+1)'(NB_CORES);
      end
      if (!w_any && bus.core_req_i[sum[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = sum[ID_W-1:0];
      end
    end
  end

  assign w_can_issue = (r_outst_cnt < c_cnt_w'(MAX_OUTST));
  assign w_fpu_req   = !rst_i && w_any && w_can_issue;
  assign w_accept    = w_fpu_req && bus.fpu_gnt_i;
  assign w_rr_next   = (w_win == ID_W'(NB_CORES-1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_gnt = '0;
    if (w_accept) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  assign bus.fpu_req_o      = w_fpu_req;
  assign bus.core_gnt_o     = w_gnt;
  assign bus.fpu_operands_o = (w_any && !rst_i) ? bus.core_operands_i[w_win*NARGS*32 +: NARGS*32] : '0;
  assign bus.fpu_op_o       = (w_any && !rst_i) ? bus.core_op_i[w_win*WOP +: WOP] : '0;
  assign bus.fpu_flags_o    = (w_any && !rst_i) ? bus.core_flags_i[w_win*NDSFLAGS +: NDSFLAGS] : '0;
  assign bus.fpu_tag_o      = (w_any && !rst_i) ? w_win : '0;

  // A response with nothing outstanding is dropped and never underflows the count.
  assign w_dec       = bus.fpu_rvalid_i && (r_outst_cnt != '0);
  assign w_tag_legal = ({1'b0, bus.fpu_rtag_i} < (ID_W+1)'(NB_CORES));

  always_comb begin
    w_rvalid = '0;
    if (!rst_i && w_dec && w_tag_legal) begin
      w_rvalid[bus.fpu_rtag_i] = 1'b1;
    end
  end

  assign bus.core_rvalid_o = w_rvalid;
  assign bus.core_rdata_o  = rst_i ? '0 : bus.fpu_rdata_i;
  assign bus.core_rflags_o = rst_i ? '0 : bus.fpu_rflags_i;
  assign bus.busy_o        = (r_outst_cnt != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_outst_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_rr_next;
      end
      case ({w_accept, w_dec})
        2'b10:   r_outst_cnt <= r_outst_cnt + 1'b1;
        2'b01:   r_outst_cnt <= r_outst_cnt - 1'b1;
        default: r_outst_cnt <= r_outst_cnt;
      endcase
    end
  end

`ifdef APU_ARB_PERF_EN
  logic [31:0] r_grant_cnt [NB_CORES];
  logic [31:0] r_stall_cnt [NB_CORES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NB_CORES; k++) begin
        r_grant_cnt[k] <= '0;
        r_stall_cnt[k] <= '0;
      end
    end else if (perf_clr_i) begin
      for (int k = 0; k < NB_CORES; k++) begin
        r_grant_cnt[k] <= '0;
        r_stall_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NB_CORES; k++) begin
        if (w_gnt[k]) begin
          r_grant_cnt[k] <= r_grant_cnt[k] + 32'd1;
        end
        if (bus.core_req_i[k] && !w_gnt[k]) begin
          r_stall_cnt[k] <= r_stall_cnt[k] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_cnt_o = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      if (perf_sel_i == ID_W'(k)) begin
        perf_cnt_o = {r_stall_cnt[k], r_grant_cnt[k]};
      end
    end
  end
`endif

endmodule

`default_nettype wire
